// File: rtl/blk2raster_out_buffer_pkg.sv
// Shared sizing helpers, sample packing order and config checks for the
// block-to-raster output buffer.
package blk2raster_out_buffer_pkg;

  localparam int DEF_MAX_SLICE_WIDTH = 2560;
  localparam int DEF_BLK_W           = 8;
  localparam int DEF_BLK_H           = 2;
  localparam int DEF_NUM_CP          = 3;
  localparam int DEF_BITS            = 14;
  localparam int DEF_PIX_PER_BEAT    = 4;

  function automatic int blk_count(input int max_w, input int blk_w);
    return (max_w + blk_w - 1) / blk_w;
  endfunction

  function automatic int beat_count(input int max_w, input int ppb);
    return max_w / ppb;
  endfunction

  // Bits needed to index 0..n-1 (never zero width).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_MAX_BLK  = blk_count(DEF_MAX_SLICE_WIDTH, DEF_BLK_W);
  localparam int DEF_BLK_CW   = cnt_w(DEF_MAX_BLK + 1);
  localparam int DEF_MAX_BEAT = beat_count(DEF_MAX_SLICE_WIDTH, DEF_PIX_PER_BEAT);
  localparam int DEF_BEAT_CW  = cnt_w(DEF_MAX_BEAT + 1);

  // Input block: component-major, then row, then column.
  function automatic int in_idx(input int cp, input int r, input int c,
                                input int blk_h, input int blk_w);
    return cp * blk_h * blk_w + r * blk_w + c;
  endfunction

  // Output beat and RAM row words: pixel-major, component minor.
  function automatic int out_idx(input int p, input int cp, input int num_cp);
    return p * num_cp + cp;
  endfunction

  function automatic bit cfg_legal(input int blk_w, input int blk_h, input int ppb);
    return (ppb > 0) && ((ppb & (ppb - 1)) == 0) && (blk_w % ppb == 0) &&
           (blk_h >= 1) && (blk_h <= 4);
  endfunction

  typedef struct packed {
    logic sof;
    logic eol;
  } beat_tag_t;

endpackage

// File: rtl/blk2raster_out_buffer_out_skid_fifo.sv
// Two-entry output FIFO carrying one beat plus its sof/eol tag; a push into a
// full FIFO is allowed in the same cycle as a pop.
module blk2raster_out_buffer_out_skid_fifo
  import blk2raster_out_buffer_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  beat_tag_t     push_tag,
  input  logic [DW-1:0] push_data,
  input  logic          pop_ready,
  output logic          out_valid,
  output beat_tag_t     out_tag,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  logic [1:0][DW-1:0] mem_d;
  beat_tag_t [1:0]    mem_t;
  logic               wptr, rptr;
  logic               do_push, do_pop;

  assign out_valid = (count != 2'd0);
  assign out_data  = mem_d[rptr];
  assign out_tag   = mem_t[rptr];
  assign do_pop    = out_valid & pop_ready;
  assign do_push   = push & ((count != 2'd2) | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_d <= '0;
      mem_t <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else if (flush) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) begin
        mem_d[wptr] <= push_data;
        mem_t[wptr] <= push_tag;
        wptr        <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/dp_ram.sv
// Simple dual-port RAM, one write and one read port, registered read data.
module dp_ram #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/blk2raster_out_buffer.sv
// Reorders BLK_W x BLK_H blocks into raster beats through two ping-pong banks
// with valid/ready on both sides.
module blk2raster_out_buffer
  import blk2raster_out_buffer_pkg::*;
#(
  parameter int MAX_SLICE_WIDTH = DEF_MAX_SLICE_WIDTH,
  parameter int BLK_W           = DEF_BLK_W,
  parameter int BLK_H           = DEF_BLK_H,
  parameter int NUM_CP          = DEF_NUM_CP,
  parameter int BITS            = DEF_BITS,
  parameter int PIX_PER_BEAT    = DEF_PIX_PER_BEAT
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    sof,
  input  logic [$clog2(MAX_SLICE_WIDTH+1)-1:0]    slice_width,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [NUM_CP*BLK_H*BLK_W*BITS-1:0]      in_blk,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [PIX_PER_BEAT*NUM_CP*BITS-1:0]     out_data,
  output logic                                    out_sof,
  output logic                                    out_eol
);

  localparam int MAX_BLK  = blk_count(MAX_SLICE_WIDTH, BLK_W);
  localparam int BLK_CW   = cnt_w(MAX_BLK + 1);
  localparam int MAX_BEAT = beat_count(MAX_SLICE_WIDTH, PIX_PER_BEAT);
  localparam int BEAT_CW  = cnt_w(MAX_BEAT + 1);
  localparam int LANES    = BLK_W / PIX_PER_BEAT;
  localparam int LANE_W   = cnt_w(LANES);
  localparam int ROW_IW   = cnt_w(BLK_H);
  localparam int PIX_W    = NUM_CP * BITS;
  localparam int BEAT_W   = PIX_PER_BEAT * PIX_W;
  localparam int ROW_W    = BLK_W * PIX_W;
  localparam int AW       = BLK_CW + 1;

  if (!cfg_legal(BLK_W, BLK_H, PIX_PER_BEAT)) begin : g_bad_cfg
    $error("blk2raster_out_buffer: illegal BLK_W/BLK_H/PIX_PER_BEAT combination");
  end

  assert property (@(posedge clk) disable iff (rst)
    sof |-> ((32'(slice_width) % PIX_PER_BEAT) == 0));

  // slice configuration
  logic [BLK_CW-1:0]  nblk, nblk_new;
  logic [BEAT_CW-1:0] nbeat, nbeat_new;
  logic               active;

  // write side
  logic [1:0]         bank_full, bf_next;
  logic               wr_bank, wb;
  logic [BLK_CW-1:0]  wr_blk, wk, nb;
  logic               accept, wr_last;

  // read side
  logic               rd_bank;
  logic [ROW_IW-1:0]  rd_row;
  logic [BEAT_CW-1:0] rd_beat;
  logic [BLK_CW-1:0]  rd_blk;
  logic [LANE_W-1:0]  rd_lane;
  logic               first, rd_last_beat, rd_last_row, issue, pop, room;
  logic [2:0]         occ;
  logic [1:0]         vld_pipe;
  logic               p_sof, p_eol;
  logic [ROW_IW-1:0]  p_row;
  logic [LANE_W-1:0]  p_lane;
  logic [1:0]         fifo_cnt;
  logic [BLK_H-1:0][ROW_W-1:0] rd_data;
  logic [BEAT_W-1:0]  push_data;
  beat_tag_t          push_tag, out_tag;

  assign nblk_new  = BLK_CW'((32'(slice_width) + BLK_W - 1) / BLK_W);
  assign nbeat_new = BEAT_CW'(32'(slice_width) / PIX_PER_BEAT);

  // A block arriving with sof becomes block 0 of bank 0 of the new slice.
  assign in_ready = sof | ~bank_full[wr_bank];
  assign accept   = in_valid & in_ready & (active | sof);
  assign wb       = sof ? 1'b0 : wr_bank;
  assign wk       = sof ? '0 : wr_blk;
  assign nb       = sof ? nblk_new : nblk;
  assign wr_last  = (nb != '0) && (wk == nb - 1'b1);

  assign rd_last_beat = (rd_beat == nbeat - 1'b1);
  assign rd_last_row  = (rd_row == ROW_IW'(BLK_H - 1));
  assign pop          = out_valid & out_ready;
  // FIFO entries plus the read in flight must leave a slot after this cycle's pop.
  assign occ          = {1'b0, fifo_cnt} + {2'b0, vld_pipe[1]};
  assign room         = occ < (3'd2 + {2'b0, pop});
  assign issue        = ~sof & bank_full[rd_bank] & room;
  assign vld_pipe[0]  = issue;

  always_comb begin
    bf_next = sof ? 2'b00 : bank_full;
    if (issue && rd_last_beat && rd_last_row) bf_next[rd_bank] = 1'b0;
    if (accept && wr_last)                    bf_next[wb]      = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nblk        <= '0;
      nbeat       <= '0;
      active      <= 1'b0;
      bank_full   <= 2'b00;
      wr_bank     <= 1'b0;
      wr_blk      <= '0;
      rd_bank     <= 1'b0;
      rd_row      <= '0;
      rd_beat     <= '0;
      rd_blk      <= '0;
      rd_lane     <= '0;
      first       <= 1'b0;
      vld_pipe[1] <= 1'b0;
      p_sof       <= 1'b0;
      p_eol       <= 1'b0;
      p_row       <= '0;
      p_lane      <= '0;
    end else begin
      bank_full <= bf_next;

      if (accept) begin
        wr_bank <= wr_last ? ~wb : wb;
        wr_blk  <= wr_last ? '0 : wk + 1'b1;
      end else if (sof) begin
        wr_bank <= 1'b0;
        wr_blk  <= '0;
      end

      if (sof) begin
        nblk    <= nblk_new;
        nbeat   <= nbeat_new;
        active  <= 1'b1;
        rd_bank <= 1'b0;
        rd_row  <= '0;
        rd_beat <= '0;
        rd_blk  <= '0;
        rd_lane <= '0;
        first   <= 1'b1;
      end else if (issue) begin
        first <= 1'b0;
        if (rd_last_beat) begin
          rd_beat <= '0;
          rd_blk  <= '0;
          rd_lane <= '0;
          if (rd_last_row) begin
            rd_row  <= '0;
            rd_bank <= ~rd_bank;
          end else begin
            rd_row <= rd_row + 1'b1;
          end
        end else begin
          rd_beat <= rd_beat + 1'b1;
          if (rd_lane == LANE_W'(LANES - 1)) begin
            rd_lane <= '0;
            rd_blk  <= rd_blk + 1'b1;
          end else begin
            rd_lane <= rd_lane + 1'b1;
          end
        end
      end

      vld_pipe[1] <= vld_pipe[0];
      p_sof       <= first;
      p_eol       <= rd_last_beat;
      p_row       <= rd_row;
      p_lane      <= rd_lane;
    end
  end

  // One RAM per block row; all rows of a block column are written together.
  for (genvar r = 0; r < BLK_H; r++) begin : g_row
    logic [ROW_W-1:0] wr_row;
    for (genvar c = 0; c < BLK_W; c++) begin : g_col
      for (genvar cp = 0; cp < NUM_CP; cp++) begin : g_cp
        assign wr_row[out_idx(c, cp, NUM_CP)*BITS +: BITS] =
          in_blk[in_idx(cp, r, c, BLK_H, BLK_W)*BITS +: BITS];
      end
    end

    dp_ram #(.DW(ROW_W), .AW(AW)) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr ({wb, wk}),
      .wdata (wr_row),
      .re    (issue),
      .raddr ({rd_bank, rd_blk}),
      .rdata (rd_data[r])
    );
  end

  assign push_data    = rd_data[p_row][p_lane*BEAT_W +: BEAT_W];
  assign push_tag.sof = p_sof;
  assign push_tag.eol = p_eol;

  blk2raster_out_buffer_out_skid_fifo #(.DW(BEAT_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (sof),
    .push      (vld_pipe[1]),
    .push_tag  (push_tag),
    .push_data (push_data),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .out_data  (out_data),
    .count     (fifo_cnt)
  );

  assign out_sof = out_tag.sof;
  assign out_eol = out_tag.eol;

endmodule

// File: tb/tb_blk2raster_out_buffer.sv
// Scoreboard bench: stimulus pushes expected raster beats, a negedge monitor
// pops and compares every accepted output beat.
module tb_blk2raster_out_buffer;

  localparam int MSW   = 2560;
  localparam int BW    = 8;
  localparam int BH    = 2;
  localparam int NCP   = 3;
  localparam int BITS  = 14;
  localparam int PPB   = 4;
  localparam int SW_W  = $clog2(MSW + 1);
  localparam int IN_W  = NCP * BH * BW * BITS;
  localparam int OUT_W = PPB * NCP * BITS;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             sof;
    logic             eol;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sof = 1'b0;
  logic [SW_W-1:0]  slice_width = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_blk = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_sof, out_eol;

  exp_t sb[$];
  int   npass = 0, ntotal = 0;
  int   cyc = 0, acc_cyc = 0;
  bit   lat_arm = 1'b0, lat_done = 1'b0;
  bit   rand_en = 1'b0, ready_fixed = 1'b0;

  blk2raster_out_buffer #(
    .MAX_SLICE_WIDTH(MSW), .BLK_W(BW), .BLK_H(BH), .NUM_CP(NCP),
    .BITS(BITS), .PIX_PER_BEAT(PPB)
  ) dut (
    .clk(clk), .rst(rst), .sof(sof), .slice_width(slice_width),
    .in_valid(in_valid), .in_ready(in_ready), .in_blk(in_blk),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail(input string name);
    ntotal++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [BITS-1:0] val(input int tag, input int y, input int x, input int cp);
    return BITS'((tag << 12) ^ (y * 256 + x * 3 + cp));
  endfunction

  function automatic logic [IN_W-1:0] mk_blk(input int tag, input int brow, input int k);
    logic [IN_W-1:0] b = '0;
    for (int cp = 0; cp < NCP; cp++)
      for (int r = 0; r < BH; r++)
        for (int c = 0; c < BW; c++)
          b[(cp*BH*BW + r*BW + c)*BITS +: BITS] = val(tag, brow*BH + r, k*BW + c, cp);
    return b;
  endfunction

  task automatic push_bank(input int tag, input int brow, input int width, input bit first);
    exp_t e;
    int nbeat = width / PPB;
    for (int r = 0; r < BH; r++)
      for (int b = 0; b < nbeat; b++) begin
        e.data = '0;
        for (int p = 0; p < PPB; p++)
          for (int cp = 0; cp < NCP; cp++)
            e.data[(p*NCP + cp)*BITS +: BITS] = val(tag, brow*BH + r, b*PPB + p, cp);
        e.sof = first && r == 0 && b == 0;
        e.eol = (b == nbeat - 1);
        sb.push_back(e);
      end
  endtask

  // Called and returns at posedge+1; holds the block until in_ready is seen.
  task automatic send_blk(input logic [IN_W-1:0] b, input bit do_sof);
    int n = 0;
    in_valid = 1'b1;
    in_blk   = b;
    sof      = do_sof;
    if (do_sof) sb.delete();
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 2000) break;
    end
    if (n > 2000) begin
      fail("in_ready_timeout");
      in_valid = 1'b0;
      sof      = 1'b0;
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      sof      = 1'b0;
      acc_cyc  = cyc;
    end
  endtask

  task automatic send_slice(input int tag, input int nbrow, input int width);
    int nblk = (width + BW - 1) / BW;
    slice_width = SW_W'(width);
    for (int br = 0; br < nbrow; br++) begin
      for (int k = 0; k < nblk; k++) send_blk(mk_blk(tag, br, k), br == 0 && k == 0);
      push_bank(tag, br, width, br == 0);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk({name, "_drained"}, 256'(sb.size()), 256'(0));
    repeat (4) @(negedge clk);
    chk({name, "_no_extra"}, 256'(out_valid), 256'(0));
    @(posedge clk); #1;
  endtask

  // out_ready driver
  initial forever begin
    @(posedge clk); #1;
    out_ready = rand_en ? 1'($urandom_range(0, 1)) : ready_fixed;
  end

  // monitor / scoreboard
  initial begin
    exp_t e;
    bit   stall_prev = 1'b0;
    logic [OUT_W+1:0] held = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (lat_arm && !lat_done && out_valid) begin
          chk("first_valid_latency", 256'(cyc - acc_cyc), 256'(2));
          lat_done = 1'b1;
        end
        if (stall_prev && out_valid)
          chk("stall_stable", 256'({out_sof, out_eol, out_data}), 256'(held));
        stall_prev = out_valid && !out_ready;
        held       = {out_sof, out_eol, out_data};
        if (out_valid && out_ready) begin
          if (sb.size() == 0) fail("unexpected_beat");
          else begin
            e = sb.pop_front();
            chk("beat", 256'({out_sof, out_eol, out_data}), 256'({e.sof, e.eol, e.data}));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_sof",   256'(out_sof),   256'(0));
    chk("rst_out_eol",   256'(out_eol),   256'(0));
    chk("rst_out_data",  256'(out_data),  256'(0));
    chk("rst_in_ready",  256'(in_ready),  256'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 16 wide, two blocks, first-valid latency
    ready_fixed = 1'b1;
    repeat (2) @(posedge clk); #1;
    send_slice(0, 1, 16);
    lat_arm = 1'b1;
    drain("w16");

    // 20 wide: three blocks, last block half unused
    send_slice(1, 1, 20);
    drain("w20");

    // both banks fill under backpressure, then release
    ready_fixed = 1'b0;
    repeat (2) @(posedge clk); #1;
    send_slice(2, 2, 16);
    in_valid = 1'b1;
    in_blk   = mk_blk(2, 2, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("in_ready_both_full", 256'(in_ready), 256'(0));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    ready_fixed = 1'b1;
    drain("stall16");

    // random backpressure, 6 block rows at 64 wide
    rand_en = 1'b1;
    send_slice(3, 6, 64);
    drain("rand64");
    rand_en = 1'b0;
    ready_fixed = 1'b0;
    repeat (2) @(posedge clk); #1;

    // sof mid-bank with a block in the same cycle
    slice_width = SW_W'(16);
    send_blk(mk_blk(1, 0, 0), 1'b1);
    send_blk(mk_blk(1, 0, 1), 1'b0);
    send_blk(mk_blk(1, 1, 0), 1'b0);
    repeat (4) @(negedge clk);
    chk("old_beat_held", 256'(out_valid), 256'(1));
    @(posedge clk); #1;
    send_blk(mk_blk(2, 0, 0), 1'b1);
    @(negedge clk);
    chk("sof_flush_valid", 256'(out_valid), 256'(0));
    @(posedge clk); #1;
    send_blk(mk_blk(2, 0, 1), 1'b0);
    push_bank(2, 0, 16, 1'b1);
    ready_fixed = 1'b1;
    drain("sof_mid");

    // reset during output, then a fresh slice
    send_slice(3, 1, 16);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", 256'(out_valid), 256'(0));
    chk("rst_mid_in_ready",  256'(in_ready),  256'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_slice(0, 1, 16);
    drain("after_rst");

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
